// File: rtl/nn_weight_loader_if.sv
`timescale 1ns/1ps
// Word-stream handshake plus the shared layer configuration bus.
// The loader connects through the slave modport; the word source and the layers see the master view.
interface nn_weight_loader_if;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] config_layer_num;
  logic [31:0] config_neuron_num;
  logic [31:0] weightValue;
  logic        weightValid;
  logic [31:0] biasValue;
  logic        biasValid;

  modport master (
    output in_data, in_valid,
    input  in_ready,
    input  config_layer_num, config_neuron_num,
    input  weightValue, weightValid, biasValue, biasValid
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready,
    output config_layer_num, config_neuron_num,
    output weightValue, weightValid, biasValue, biasValid
  );
endinterface

// File: rtl/nn_weight_loader.sv
`timescale 1ns/1ps
// nn_weight_loader: walks every layer/neuron and writes one stream word per weight onto the config bus.
// Define NN_LOADER_BIAS_EN to also consume one bias word after each neuron's weights.
module nn_weight_loader #(
  parameter int          NUM_LAYERS = 4,
  parameter logic [63:0] LAYER_NN   = {16'd10, 16'd10, 16'd10, 16'd10},
  parameter logic [63:0] LAYER_NW   = {16'd10, 16'd10, 16'd30, 16'd784}
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  nn_weight_loader_if.slave  bus,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_WEIGHT = 3'd2,
    ST_BIAS   = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam logic [15:0] LAST_LAYER = 16'(NUM_LAYERS - 1);

  // Elaboration-time guard against empty layers or an unsupported layer count.
  if (NUM_LAYERS < 1 || NUM_LAYERS > 4) begin : g_bad_layers
    $fatal(1, "nn_weight_loader: NUM_LAYERS must be 1..4");
  end
  for (genvar g = 0; g < 4; g++) begin : g_cfg_chk
    if (g < NUM_LAYERS && (LAYER_NN[16*g +: 16] == 16'd0 || LAYER_NW[16*g +: 16] == 16'd0)) begin : g_zero
      $fatal(1, "nn_weight_loader: layer %0d has a zero neuron or weight count", g + 1);
    end
  end

  state_e      state_r;
  state_e      next_state_s;
  state_e      seq_next_s;
  state_e      advance_state_s;
  logic [15:0] layer_idx_r;
  logic [15:0] neuron_idx_r;
  logic [15:0] weight_cnt_r;
  logic [5:0]  field_base_s;
  logic [15:0] nn_s;
  logic [15:0] nw_s;
  logic        xfer_s;
  logic        abort_s;
  logic        last_weight_s;
  logic        last_neuron_s;
  logic        last_layer_s;
  logic        word_last_s;
  logic [31:0] cfg_layer_r;
  logic [31:0] cfg_neuron_r;
  logic [31:0] weight_value_r;
  logic        weight_valid_r;
  logic        done_r;

  assign field_base_s    = {layer_idx_r[1:0], 4'd0};
  assign nn_s            = LAYER_NN[field_base_s +: 16];
  assign nw_s            = LAYER_NW[field_base_s +: 16];
  assign bus.in_ready    = (state_r == ST_WEIGHT) || (state_r == ST_BIAS);
  assign busy            = (state_r != ST_IDLE);
  assign xfer_s          = bus.in_valid && bus.in_ready;
  assign abort_s         = abort && (state_r != ST_IDLE);
  assign last_weight_s   = (weight_cnt_r == nw_s - 16'd1);
  assign last_neuron_s   = (neuron_idx_r == nn_s - 16'd1);
  assign last_layer_s    = (layer_idx_r == LAST_LAYER);
  assign advance_state_s = (last_neuron_s && last_layer_s) ? ST_DONE : ST_SETUP;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode; word_last_s flags the final word of the current neuron.
  always_comb begin
    seq_next_s  = state_r;
    word_last_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) seq_next_s = ST_SETUP;
        else       seq_next_s = ST_IDLE;
      end
      ST_SETUP: seq_next_s = ST_WEIGHT;
      ST_WEIGHT: begin
        if (xfer_s && last_weight_s) begin
`ifdef NN_LOADER_BIAS_EN
          seq_next_s  = ST_BIAS;
`else
          seq_next_s  = advance_state_s;
          word_last_s = 1'b1;
`endif
        end else begin
          seq_next_s = ST_WEIGHT;
        end
      end
`ifdef NN_LOADER_BIAS_EN
      ST_BIAS: begin
        if (xfer_s) begin
          seq_next_s  = advance_state_s;
          word_last_s = 1'b1;
        end else begin
          seq_next_s = ST_BIAS;
        end
      end
`endif
      ST_DONE: seq_next_s = ST_IDLE;
      default: seq_next_s = ST_IDLE;
    endcase
    next_state_s = abort_s ? ST_IDLE : seq_next_s;
  end

  // Counters, config registers and write strobes; abort clears counters but keeps the same-cycle strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      layer_idx_r    <= 16'd0;
      neuron_idx_r   <= 16'd0;
      weight_cnt_r   <= 16'd0;
      cfg_layer_r    <= 32'd0;
      cfg_neuron_r   <= 32'd0;
      weight_value_r <= 32'd0;
      weight_valid_r <= 1'b0;
      done_r         <= 1'b0;
    end else begin
      weight_valid_r <= 1'b0;
      done_r         <= (state_r == ST_DONE) && !abort;
      if (state_r == ST_IDLE && start) begin
        layer_idx_r  <= 16'd0;
        neuron_idx_r <= 16'd0;
      end
      if (state_r == ST_SETUP) begin
        cfg_layer_r  <= {16'd0, layer_idx_r + 16'd1};
        cfg_neuron_r <= {16'd0, neuron_idx_r};
        weight_cnt_r <= 16'd0;
      end
      if (state_r == ST_WEIGHT && xfer_s) begin
        weight_value_r <= bus.in_data;
        weight_valid_r <= 1'b1;
        weight_cnt_r   <= weight_cnt_r + 16'd1;
      end
      if (word_last_s) begin
        if (!last_neuron_s) begin
          neuron_idx_r <= neuron_idx_r + 16'd1;
        end else if (!last_layer_s) begin
          neuron_idx_r <= 16'd0;
          layer_idx_r  <= layer_idx_r + 16'd1;
        end
      end
      if (abort_s) begin
        layer_idx_r  <= 16'd0;
        neuron_idx_r <= 16'd0;
        weight_cnt_r <= 16'd0;
      end
    end
  end

`ifdef NN_LOADER_BIAS_EN
  logic [31:0] bias_value_r;
  logic        bias_valid_r;

  // Bias write strobe, one cycle per accepted bias word.
  always_ff @(posedge clk) begin
    if (rst) begin
      bias_value_r <= 32'd0;
      bias_valid_r <= 1'b0;
    end else begin
      bias_valid_r <= 1'b0;
      if (state_r == ST_BIAS && xfer_s) begin
        bias_value_r <= bus.in_data;
        bias_valid_r <= 1'b1;
      end
    end
  end

  assign bus.biasValue = bias_value_r;
  assign bus.biasValid = bias_valid_r;
`else
  assign bus.biasValue = 32'd0;
  assign bus.biasValid = 1'b0;
`endif

  assign bus.config_layer_num  = cfg_layer_r;
  assign bus.config_neuron_num = cfg_neuron_r;
  assign bus.weightValue       = weight_value_r;
  assign bus.weightValid       = weight_valid_r;
  assign done                  = done_r;

endmodule

// File: tb/tb_nn_weight_loader.sv
`timescale 1ns/1ps
// Self-checking bench for nn_weight_loader: 2-layer network (L1: 2 neurons x 3 weights, L2: 1 neuron x 2 weights).
module tb_nn_weight_loader;

  localparam int          NUM_LAYERS = 2;
  localparam logic [63:0] LAYER_NN   = {16'd1, 16'd1, 16'd1, 16'd2};
  localparam logic [63:0] LAYER_NW   = {16'd1, 16'd1, 16'd2, 16'd3};
`ifdef NN_LOADER_BIAS_EN
  localparam bit BIAS_EN = 1'b1;
`else
  localparam bit BIAS_EN = 1'b0;
`endif
  localparam int TOTAL_WORDS = BIAS_EN ? 11 : 8;

  typedef struct {
    logic        is_bias;
    logic [31:0] layer;
    logic [31:0] neuron;
    logic [31:0] data;
  } sb_t;

  typedef struct {
    logic       start;
    logic       in_valid;
    logic [4:0] exp;       // {busy, in_ready, weightValid, biasValid, done}
    logic       chk_busy;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic abort;
  logic busy;
  logic done;

  nn_weight_loader_if bus();

  nn_weight_loader #(
    .NUM_LAYERS (NUM_LAYERS),
    .LAYER_NN   (LAYER_NN),
    .LAYER_NW   (LAYER_NW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .abort (abort),
    .bus   (bus),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   word_idx = 0;
  int   done_cnt = 0;
  sb_t  model[$];
  sb_t  sb_q[$];
  sb_t  mon_e;
  vec_t vecs[19];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
  endtask

  // Expected load order: each neuron's weights, then (optionally) its bias.
  task automatic build_model();
    sb_t e;
    model.delete();
    for (int l = 0; l < 2; l++) begin
      for (int n = 0; n < ((l == 0) ? 2 : 1); n++) begin
        for (int w = 0; w < ((l == 0) ? 3 : 2); w++) begin
          e.is_bias = 1'b0; e.layer = 32'(l + 1); e.neuron = 32'(n); e.data = 32'd0;
          model.push_back(e);
        end
        if (BIAS_EN) begin
          e.is_bias = 1'b1; e.layer = 32'(l + 1); e.neuron = 32'(n); e.data = 32'd0;
          model.push_back(e);
        end
      end
    end
  endtask

  // Drive one cycle of inputs; a handshake that will be taken at the next edge goes to the scoreboard.
  task automatic drive(input logic st, input logic vld, input logic ab);
    sb_t e;
    start        = st;
    abort        = ab;
    bus.in_valid = vld;
    bus.in_data  = $urandom();
    if (vld && bus.in_ready && !rst) begin
      if (word_idx < model.size()) begin
        e      = model[word_idx];
        e.data = bus.in_data;
        sb_q.push_back(e);
      end else begin
        check("extra_word", 64'(word_idx), 64'(model.size()));
      end
      word_idx++;
    end
    @(negedge clk);
  endtask

  task automatic new_load();
    word_idx = 0;
    done_cnt = 0;
  endtask

  // Strobe monitor: every write must match the next scoreboard entry, tag included.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (bus.weightValid || bus.biasValid) begin
      if (sb_q.size() == 0) begin
        check("strobe_without_word", 64'(sb_q.size()), 64'd1);
      end else begin
        mon_e = sb_q.pop_front();
        check("strobe",
              {14'd0, bus.biasValid, bus.weightValid, bus.config_layer_num[7:0], bus.config_neuron_num[7:0],
               (bus.biasValid ? bus.biasValue : bus.weightValue)},
              {14'd0, mon_e.is_bias, !mon_e.is_bias, mon_e.layer[7:0], mon_e.neuron[7:0], mon_e.data});
      end
    end
  end

  initial begin
    logic [31:0] wv_m, bv_m, dn_m, bz_m, rd_m;
    logic [4:0]  act, msk;
    logic        found;

`ifdef NN_LOADER_BIAS_EN
    wv_m = 32'h0000_6738; bv_m = 32'h0000_8840; dn_m = 32'h0001_0000;
    bz_m = 32'h0000_FFFE; rd_m = 32'h0000_77BC;
`else
    wv_m = 32'h0000_1BB8; bv_m = 32'h0000_0000; dn_m = 32'h0000_2000;
    bz_m = 32'h0000_1FFE; rd_m = 32'h0000_0DDC;
`endif
    for (int c = 0; c < 19; c++) begin
      vecs[c].start    = (c == 0) || (c == 8);
      vecs[c].in_valid = 1'b1;
      vecs[c].exp      = {bz_m[c], rd_m[c], wv_m[c], bv_m[c], dn_m[c]};
      vecs[c].chk_busy = !dn_m[c];
    end
    build_model();

    rst = 1'b1; start = 1'b0; abort = 1'b0; bus.in_valid = 1'b0; bus.in_data = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_config_layer", 64'(bus.config_layer_num), 64'd0);
    check("rst_config_neuron", 64'(bus.config_neuron_num), 64'd0);
    check("rst_values", {bus.weightValue, bus.biasValue}, 64'd0);
    check("rst_flags", {59'd0, bus.weightValid, bus.biasValid, done, busy, bus.in_ready}, 64'd0);
    rst = 1'b0;

    // in_valid high in IDLE must not consume words.
    new_load();
    for (int k = 0; k < 4; k++) begin
      check("idle_in_ready", 64'(bus.in_ready), 64'd0);
      drive(1'b0, 1'b1, 1'b0);
    end
    check("idle_words", 64'(word_idx), 64'd0);

    // Continuous-valid load, cycle-accurate; a second start at cycle 8 is ignored.
    new_load();
    for (int c = 0; c < 19; c++) begin
      act = {busy, bus.in_ready, bus.weightValid, bus.biasValid, done};
      msk = {vecs[c].chk_busy, 4'b1111};
      check($sformatf("cycle%0d", c), 64'(act & msk), 64'(vecs[c].exp & msk));
      drive(vecs[c].start, vecs[c].in_valid, 1'b0);
    end
    check("t1_words", 64'(word_idx), 64'(TOTAL_WORDS));
    check("t1_done_count", 64'(done_cnt), 64'd1);
    check("t1_sb_empty", 64'(sb_q.size()), 64'd0);
    check("t1_config_hold", {bus.config_layer_num, bus.config_neuron_num}, {32'd2, 32'd0});

    // Valid toggling every cycle: same words, same order, one done.
    new_load();
    drive(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 60; k++) drive(1'b0, (k % 2) == 1, 1'b0);
    check("t2_words", 64'(word_idx), 64'(TOTAL_WORDS));
    check("t2_done_count", 64'(done_cnt), 64'd1);
    check("t2_sb_empty", 64'(sb_q.size()), 64'd0);

    // Abort during layer-2 WEIGHT, with a transfer in the abort cycle.
    new_load();
    found = 1'b0;
    drive(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 40 && !found; k++) begin
      if (bus.config_layer_num == 32'd2 && bus.in_ready) found = 1'b1;
      else drive(1'b0, 1'b1, 1'b0);
    end
    check("t3_reach_layer2", 64'(found), 64'd1);
    drive(1'b0, 1'b1, 1'b1);
    check("t3_abort_idle", {62'd0, busy, bus.in_ready}, 64'd0);
    for (int k = 0; k < 5; k++) drive(1'b0, 1'b0, 1'b0);
    check("t3_no_done", 64'(done_cnt), 64'd0);
    check("t3_sb_empty", 64'(sb_q.size()), 64'd0);
    new_load();
    drive(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 30; k++) drive(1'b0, 1'b1, 1'b0);
    check("t3_restart_words", 64'(word_idx), 64'(TOTAL_WORDS));
    check("t3_restart_done", 64'(done_cnt), 64'd1);

    // Reset in cycle 5 (bias slot of neuron 0 when biases are enabled).
    new_load();
    drive(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) drive(1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b0);
    check("t4_rst_config", {bus.config_layer_num, bus.config_neuron_num}, 64'd0);
    check("t4_rst_values", {bus.weightValue, bus.biasValue}, 64'd0);
    check("t4_rst_flags", {59'd0, bus.weightValid, bus.biasValid, done, busy, bus.in_ready}, 64'd0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 1'b0);
    check("t4_sb_empty", 64'(sb_q.size()), 64'd0);
    check("t4_no_done", 64'(done_cnt), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
